// File: rtl/rx_cmd_sequencer_pkg.sv
// Shared opcodes, FSM state encoding and ALU operand slots for the UART command sequencer.
package rx_cmd_pkg;

    localparam logic [7:0] OPC_RF_WR   = 8'hAA;
    localparam logic [7:0] OPC_RF_RD   = 8'hBB;
    localparam logic [7:0] OPC_ALU_OPS = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    localparam int ALU_A_ADDR = 0;
    localparam int ALU_B_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
        OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI
    } state_t;

    // States that are still collecting frame bytes (rx_err aborts, timeout applies)
    function automatic logic is_collect(input state_t s);
        return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR) ||
               (s == OP_A) || (s == OP_B) || (s == ALU_FUN);
    endfunction

endpackage

// File: rtl/rx_cmd_sequencer_if.sv
// Bus bundle between the command sequencer and its UART RX/TX, register file and ALU.
interface rx_cmd_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [DATA_W-1:0]   rx_data;
    logic                rx_valid;
    logic                rx_err;
    logic                rf_wr_en;
    logic                rf_rd_en;
    logic [ADDR_W-1:0]   rf_addr;
    logic [DATA_W-1:0]   rf_wr_data;
    logic [DATA_W-1:0]   rf_rd_data;
    logic                rf_rd_valid;
    logic                alu_en;
    logic [3:0]          alu_fun;
    logic [2*DATA_W-1:0] alu_out;
    logic                alu_valid;
    logic                clk_gate_en;
    logic [DATA_W-1:0]   tx_data;
    logic                tx_valid;
    logic                tx_full;
    logic                cmd_err;

    modport master (
        input  rx_data, rx_valid, rx_err, rf_rd_data, rf_rd_valid, alu_out, alu_valid, tx_full,
        output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, clk_gate_en,
               tx_data, tx_valid, cmd_err
    );

    modport slave (
        output rx_data, rx_valid, rx_err, rf_rd_data, rf_rd_valid, alu_out, alu_valid, tx_full,
        input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, clk_gate_en,
               tx_data, tx_valid, cmd_err
    );

endinterface

// File: rtl/rx_frame_timer.sv
// Inter-byte timeout counter: cleared on restart or when not running, pulses expire at TIMEOUT_CYCLES.
module rx_frame_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    input  logic restart,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign expire = run && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                 cnt <= '0;
        else if (restart || !run) cnt <= '0;
        else if (!expire)         cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/rx_cmd_sequencer.sv
// Frame decoder/sequencer for UART commands: RF write/read, ALU ops, response bytes to TX FIFO.
// Optional inter-byte timeout enabled by defining RX_CMD_TIMEOUT_EN.
module rx_cmd_sequencer
    import rx_cmd_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             CLK,
    input  logic             RST,
    rx_cmd_sequencer_if.master bus
);
    state_t state, state_nx;

    logic              rf_wr_en_q, rf_wr_en_nx;
    logic              rf_rd_en_q, rf_rd_en_nx;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_nx;
    logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_nx;
    logic              alu_en_q, alu_en_nx;
    logic [3:0]        alu_fun_q, alu_fun_nx;
    logic              cg_q, cg_nx;
    logic [DATA_W-1:0] tx_data_q, tx_data_nx;
    logic              tx_valid_q, tx_valid_nx;
    logic [DATA_W-1:0] res_hi_q, res_hi_nx;
    logic              cmd_err_q, cmd_err_nx;

    logic rx_byte, tx_xfer, tmo_exp;

    // rx_err suppresses a coincident byte
    assign rx_byte = bus.rx_valid && !bus.rx_err;
    assign tx_xfer = tx_valid_q && !bus.tx_full;

`ifdef RX_CMD_TIMEOUT_EN
    // Every accepted byte in a timed state advances the FSM, so a state change restarts the count
    rx_frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .run     (is_collect(state)),
        .restart (state_nx != state),
        .expire  (tmo_exp)
    );
`else
    assign tmo_exp = 1'b0;
`endif

    always_comb begin
        state_nx      = state;
        rf_wr_en_nx   = 1'b0;
        rf_rd_en_nx   = 1'b0;
        alu_en_nx     = 1'b0;
        cmd_err_nx    = 1'b0;
        rf_addr_nx    = rf_addr_q;
        rf_wr_data_nx = rf_wr_data_q;
        alu_fun_nx    = alu_fun_q;
        cg_nx         = cg_q;
        tx_data_nx    = tx_data_q;
        tx_valid_nx   = tx_valid_q;
        res_hi_nx     = res_hi_q;

        if (is_collect(state) && (bus.rx_err || tmo_exp)) begin
            cmd_err_nx = 1'b1;
            state_nx   = IDLE;
        end else begin
            unique case (state)
                IDLE: if (rx_byte) begin
                    if      (bus.rx_data == DATA_W'(OPC_RF_WR))   state_nx = WR_ADDR;
                    else if (bus.rx_data == DATA_W'(OPC_RF_RD))   state_nx = RD_ADDR;
                    else if (bus.rx_data == DATA_W'(OPC_ALU_OPS)) state_nx = OP_A;
                    else if (bus.rx_data == DATA_W'(OPC_ALU_NOP)) state_nx = ALU_FUN;
                    else                                          cmd_err_nx = 1'b1;
                end
                WR_ADDR: if (rx_byte) begin
                    rf_addr_nx = bus.rx_data[ADDR_W-1:0];
                    state_nx   = WR_DATA;
                end
                WR_DATA: if (rx_byte) begin
                    rf_wr_data_nx = bus.rx_data;
                    rf_wr_en_nx   = 1'b1;
                    state_nx      = IDLE;
                end
                RD_ADDR: if (rx_byte) begin
                    rf_addr_nx  = bus.rx_data[ADDR_W-1:0];
                    rf_rd_en_nx = 1'b1;
                    state_nx    = RD_WAIT;
                end
                RD_WAIT: if (bus.rf_rd_valid) begin
                    tx_data_nx  = bus.rf_rd_data;
                    tx_valid_nx = 1'b1;
                    state_nx    = TX_HI;
                end
                OP_A: if (rx_byte) begin
                    rf_addr_nx    = ADDR_W'(ALU_A_ADDR);
                    rf_wr_data_nx = bus.rx_data;
                    rf_wr_en_nx   = 1'b1;
                    state_nx      = OP_B;
                end
                OP_B: if (rx_byte) begin
                    rf_addr_nx    = ADDR_W'(ALU_B_ADDR);
                    rf_wr_data_nx = bus.rx_data;
                    rf_wr_en_nx   = 1'b1;
                    state_nx      = ALU_FUN;
                end
                ALU_FUN: if (rx_byte) begin
                    alu_fun_nx = bus.rx_data[3:0];
                    cg_nx      = 1'b1;
                    alu_en_nx  = 1'b1;
                    state_nx   = ALU_WAIT;
                end
                ALU_WAIT: if (bus.alu_valid) begin
                    tx_data_nx  = bus.alu_out[DATA_W-1:0];
                    res_hi_nx   = bus.alu_out[2*DATA_W-1:DATA_W];
                    tx_valid_nx = 1'b1;
                    cg_nx       = 1'b0;
                    state_nx    = TX_LO;
                end
                TX_LO: if (tx_xfer) begin
                    tx_data_nx = res_hi_q;
                    state_nx   = TX_HI;
                end
                TX_HI: if (tx_xfer) begin
                    tx_valid_nx = 1'b0;
                    state_nx    = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            alu_en_q     <= 1'b0;
            alu_fun_q    <= '0;
            cg_q         <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            res_hi_q     <= '0;
            cmd_err_q    <= 1'b0;
        end else begin
            state        <= state_nx;
            rf_wr_en_q   <= rf_wr_en_nx;
            rf_rd_en_q   <= rf_rd_en_nx;
            rf_addr_q    <= rf_addr_nx;
            rf_wr_data_q <= rf_wr_data_nx;
            alu_en_q     <= alu_en_nx;
            alu_fun_q    <= alu_fun_nx;
            cg_q         <= cg_nx;
            tx_data_q    <= tx_data_nx;
            tx_valid_q   <= tx_valid_nx;
            res_hi_q     <= res_hi_nx;
            cmd_err_q    <= cmd_err_nx;
        end
    end

    assign bus.rf_wr_en    = rf_wr_en_q;
    assign bus.rf_rd_en    = rf_rd_en_q;
    assign bus.rf_addr     = rf_addr_q;
    assign bus.rf_wr_data  = rf_wr_data_q;
    assign bus.alu_en      = alu_en_q;
    assign bus.alu_fun     = alu_fun_q;
    assign bus.clk_gate_en = cg_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_rx_cmd_sequencer.sv
// Scoreboard bench for rx_cmd_sequencer: expected strobes/tx bytes queued at stimulus, popped on DUT output.
module tb_rx_cmd_sequencer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    localparam logic [7:0] K_WR  = 8'd1;
    localparam logic [7:0] K_RD  = 8'd2;
    localparam logic [7:0] K_ALU = 8'd3;
    localparam logic [7:0] K_TX  = 8'd4;
    localparam logic [7:0] K_ERR = 8'd5;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    rx_cmd_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifc ();

    rx_cmd_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (ifc)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) $display("FAIL %s: got %h want %h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (q.size() == 0) chk({tag, "_unexpected"}, obs, 32'h0);
        else begin
            e = q.pop_front();
            chk(tag, obs, e);
        end
    endtask

    function automatic logic [31:0] ev(input logic [7:0] k, input logic [7:0] a, input logic [15:0] d);
        return {k, a, d};
    endfunction

    // Output monitor: every strobe / tx transfer must match the head of the queue
    always @(negedge CLK) if (RST) begin
        if (ifc.rf_wr_en) pop_chk("rf_wr", ev(K_WR, {4'h0, ifc.rf_addr}, {8'h0, ifc.rf_wr_data}));
        if (ifc.rf_rd_en) pop_chk("rf_rd", ev(K_RD, {4'h0, ifc.rf_addr}, 16'h0));
        if (ifc.alu_en) begin
            pop_chk("alu_en", ev(K_ALU, {4'h0, ifc.alu_fun}, 16'h0));
            chk("cg_on", {31'h0, ifc.clk_gate_en}, 32'h1);
        end
        if (ifc.tx_valid && !ifc.tx_full) pop_chk("tx", ev(K_TX, 8'h0, {8'h0, ifc.tx_data}));
        if (ifc.cmd_err) pop_chk("cmd_err", ev(K_ERR, 8'h0, 16'h0));
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        ifc.rx_data  = b;
        ifc.rx_valid = 1'b1;
        tick();
        ifc.rx_valid = 1'b0;
    endtask

    task automatic drain;
        for (int i = 0; i < 100 && q.size() != 0; i++) tick();
        tick();
        chk("drain", q.size(), 32'h0);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_wr"},  {31'h0, ifc.rf_wr_en},    32'h0);
        chk({tag, "_rd"},  {31'h0, ifc.rf_rd_en},    32'h0);
        chk({tag, "_alu"}, {31'h0, ifc.alu_en},      32'h0);
        chk({tag, "_cg"},  {31'h0, ifc.clk_gate_en}, 32'h0);
        chk({tag, "_txv"}, {31'h0, ifc.tx_valid},    32'h0);
        chk({tag, "_err"}, {31'h0, ifc.cmd_err},     32'h0);
        chk({tag, "_bus"}, {ifc.tx_data, ifc.rf_wr_data, 4'h0, ifc.rf_addr, 4'h0, ifc.alu_fun}, 32'h0);
    endtask

    initial begin
        ifc.rx_data = '0; ifc.rx_valid = 1'b0; ifc.rx_err = 1'b0;
        ifc.rf_rd_data = '0; ifc.rf_rd_valid = 1'b0;
        ifc.alu_out = '0; ifc.alu_valid = 1'b0; ifc.tx_full = 1'b0;

        repeat (3) tick();
        chk_idle_outs("reset");
        RST = 1'b1;
        tick();

        // RF write
        q.push_back(ev(K_WR, 8'h05, 16'h003C));
        send(8'hAA); send(8'h05); send(8'h3C);
        drain();

        // RF read with TX back-pressure
        q.push_back(ev(K_RD, 8'h02, 16'h0));
        send(8'hBB); send(8'h02);
        drain();
        ifc.tx_full = 1'b1;
        ifc.rf_rd_data = 8'h77; ifc.rf_rd_valid = 1'b1;
        tick();
        ifc.rf_rd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("hold_txv", {31'h0, ifc.tx_valid}, 32'h1);
            chk("hold_txd", {24'h0, ifc.tx_data}, 32'h77);
            tick();
        end
        q.push_back(ev(K_TX, 8'h0, 16'h0077));
        ifc.tx_full = 1'b0;
        drain();
        chk("rd_txv_low", {31'h0, ifc.tx_valid}, 32'h0);

        // ALU with operands, two-byte reply
        q.push_back(ev(K_WR, 8'h00, 16'h0012));
        q.push_back(ev(K_WR, 8'h01, 16'h0034));
        q.push_back(ev(K_ALU, 8'h00, 16'h0));
        send(8'hCC); send(8'h12); send(8'h34); send(8'h00);
        tick(); tick();
        chk("cg_wait", {31'h0, ifc.clk_gate_en}, 32'h1);
        q.push_back(ev(K_TX, 8'h0, 16'h0046));
        q.push_back(ev(K_TX, 8'h0, 16'h0000));
        ifc.alu_out = 16'h0046; ifc.alu_valid = 1'b1;
        tick();
        ifc.alu_valid = 1'b0;
        drain();
        chk("cg_off", {31'h0, ifc.clk_gate_en}, 32'h0);

        // Unknown opcode then a normal frame
        q.push_back(ev(K_ERR, 8'h0, 16'h0));
        send(8'h5A);
        q.push_back(ev(K_WR, 8'h01, 16'h00FF));
        send(8'hAA); send(8'h01); send(8'hFF);
        drain();

        // rx_err mid-frame aborts without a write
        q.push_back(ev(K_ERR, 8'h0, 16'h0));
        send(8'hAA); send(8'h03);
        ifc.rx_err = 1'b1; ifc.rx_data = 8'h44; ifc.rx_valid = 1'b1;
        tick();
        ifc.rx_err = 1'b0; ifc.rx_valid = 1'b0;
        drain();

        // Reset while in OP_B, then a normal frame from IDLE
        q.push_back(ev(K_WR, 8'h00, 16'h0012));
        send(8'hCC); send(8'h12);
        drain();
        RST = 1'b0;
        #1;
        chk_idle_outs("midrst");
        tick();
        RST = 1'b1;
        tick();
        q.push_back(ev(K_WR, 8'h09, 16'h005A));
        send(8'hAA); send(8'h09); send(8'h5A);
        drain();

        // Partial frame followed by a long gap
        send(8'hAA);
`ifdef RX_CMD_TIMEOUT_EN
        q.push_back(ev(K_ERR, 8'h0, 16'h0));
        repeat (20) tick();
`else
        repeat (20) tick();
        q.push_back(ev(K_WR, 8'h07, 16'h0099));
        send(8'h07); send(8'h99);
`endif
        drain();

        chk("final_q", q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
